// File: rtl/keypad_encoder.sv
// Keypad front end: synchronizes and debounces ten digit buttons, emits digit + one-cycle press pulse.
// Latency: KEY_PRESS rises DEBOUNCE_CYCLES+2 edges after a stable key is first sampled.
// Backpressure: none; presses while ENABLE=0 are ignored, a held key never repeats.
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENABLE,
  input  logic [9:0] KEY_RAW,
  output logic [3:0] ITEM_CODE,
  output logic       KEY_PRESS,
  output logic       MULTI_KEY
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [9:0]       s1;
  logic [9:0]       s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cand;
  logic [9:0]       cand_onehot;
  logic [3:0]       ones;
  logic [3:0]       idx;
  logic             single;
  logic             chord;

  assign cand_onehot = 10'b1 << cand;

  // Population count and index of the highest set bit of the synchronized vector.
  always_comb begin
    ones = 4'd0;
    idx  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (s2[i]) begin
        ones = ones + 4'd1;
        idx  = 4'(i);
      end
    end
  end

  assign single = (ones == 4'd1);
  assign chord  = (ones > 4'd1);

  // Two-flop synchronizer; raw buttons are asynchronous to CLK.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= KEY_RAW;
      s2 <= s1;
    end
  end

  // Chord flag is informational only and lags s2 by one cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      MULTI_KEY <= 1'b0;
    end else begin
      MULTI_KEY <= chord;
    end
  end

  // Debounce FSM: press needs DEBOUNCE_CYCLES stable samples, release likewise before re-arming.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 4'd0;
      ITEM_CODE <= 4'd0;
      KEY_PRESS <= 1'b0;
    end else begin
      KEY_PRESS <= 1'b0;
      case (state)
        IDLE: begin
          if (ENABLE && single) begin
            cand  <= idx;
            cnt   <= CNT_W'(1);
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!ENABLE || (s2 != cand_onehot)) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            ITEM_CODE <= cand;
            KEY_PRESS <= 1'b1;
            state     <= PRESSED;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          // Extra keys while held are ignored; only a fully released vector ends the press.
          if (s2 == '0) begin
            cnt   <= CNT_W'(1);
            state <= RELEASE;
          end
        end
        RELEASE: begin
          // Release chatter returns to PRESSED without a new pulse.
          if (s2 != '0) begin
            state <= PRESSED;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: table of input segments with expected pulses, plus corner sequences.
// Each segment holds inputs for N cycles, counts KEY_PRESS high cycles and the offset of the first one.
// Outputs are sampled 1 time unit after each rising edge.
module tb_keypad_encoder;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       ENABLE;
  logic [9:0] KEY_RAW;
  logic [3:0] ITEM_CODE;
  logic       KEY_PRESS;
  logic       MULTI_KEY;

  int checks = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  keypad_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ENABLE    (ENABLE),
    .KEY_RAW   (KEY_RAW),
    .ITEM_CODE (ITEM_CODE),
    .KEY_PRESS (KEY_PRESS),
    .MULTI_KEY (MULTI_KEY)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [9:0] key;
    int         cycles;
    int         exp_pulses;
    int         exp_at;
    logic [3:0] exp_code;
    logic       exp_multi;
  } seg_t;

  seg_t vecs[19];

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_bits(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Hold one input combination for a number of cycles, then compare what was observed.
  task automatic run_seg(input string name, input logic rst_n, input logic en,
                         input logic [9:0] key, input int cycles, input int exp_pulses,
                         input int exp_at, input logic [3:0] exp_code, input logic exp_multi);
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    for (int c = 0; c < cycles; c++) begin
      RST_N   = rst_n;
      ENABLE  = en;
      KEY_RAW = key;
      @(posedge CLK);
      #1;
      if (KEY_PRESS !== 1'b0) begin
        if (first < 0) first = c;
        pulses++;
      end
    end
    check_int({name, " pulses"}, pulses, exp_pulses);
    check_int({name, " pulse_at"}, first, exp_at);
    check_bits({name, " item_code"}, ITEM_CODE, exp_code);
    check_bits({name, " multi_key"}, {3'b000, MULTI_KEY}, {3'b000, exp_multi});
  endtask

  initial begin
    RST_N   = 1'b0;
    ENABLE  = 1'b1;
    KEY_RAW = '0;

    //          rst   en    key      cyc pulses at  code   multi
    vecs[0]  = '{1'b0, 1'b1, 10'h000, 2,  0,     -1, 4'd0, 1'b0}; // reset state
    vecs[1]  = '{1'b1, 1'b1, 10'h002, 10, 1,      6, 4'd1, 1'b0}; // clean digit 1
    vecs[2]  = '{1'b1, 1'b1, 10'h000, 8,  0,     -1, 4'd1, 1'b0}; // release, code held
    vecs[3]  = '{1'b1, 1'b0, 10'h004, 10, 0,     -1, 4'd1, 1'b0}; // disabled digit 2
    // Key already through the synchronizer, so DEBOUNCE starts on the first enabled edge.
    vecs[4]  = '{1'b1, 1'b1, 10'h004, 10, 1,      4, 4'd2, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 10'h000, 8,  0,     -1, 4'd2, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 10'h018, 6,  0,     -1, 4'd2, 1'b1}; // chord 3+4
    vecs[7]  = '{1'b1, 1'b1, 10'h008, 10, 1,      6, 4'd3, 1'b0}; // drop 4, keep 3
    vecs[8]  = '{1'b1, 1'b1, 10'h000, 8,  0,     -1, 4'd3, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 10'h001, 3,  0,     -1, 4'd3, 1'b0}; // start digit 0
    vecs[10] = '{1'b1, 1'b1, 10'h003, 6,  0,     -1, 4'd3, 1'b1}; // chord aborts debounce
    vecs[11] = '{1'b1, 1'b1, 10'h000, 8,  0,     -1, 4'd3, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 10'h020, 10, 1,      6, 4'd5, 1'b0}; // digit 5
    vecs[13] = '{1'b1, 1'b0, 10'h020, 3,  0,     -1, 4'd5, 1'b0}; // drop enable while held
    vecs[14] = '{1'b1, 1'b1, 10'h020, 10, 0,     -1, 4'd5, 1'b0}; // held key must not re-fire
    vecs[15] = '{1'b1, 1'b1, 10'h000, 8,  0,     -1, 4'd5, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 10'h080, 4,  0,     -1, 4'd5, 1'b0}; // digit 7 into debounce
    vecs[17] = '{1'b1, 1'b0, 10'h080, 4,  0,     -1, 4'd5, 1'b0}; // enable drop aborts
    vecs[18] = '{1'b1, 1'b1, 10'h000, 8,  0,     -1, 4'd5, 1'b0};

    for (int i = 0; i < 19; i++) begin
      run_seg($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].en, vecs[i].key, vecs[i].cycles,
              vecs[i].exp_pulses, vecs[i].exp_at, vecs[i].exp_code, vecs[i].exp_multi);
    end

    // Press bounce on digit 6: brief captures abort, stable key fires once.
    for (int b = 0; b < 3; b++) begin
      run_seg($sformatf("bounce_on%0d", b),  1'b1, 1'b1, 10'h040, 1, 0, -1, 4'd5, 1'b0);
      run_seg($sformatf("bounce_off%0d", b), 1'b1, 1'b1, 10'h000, 1, 0, -1, 4'd5, 1'b0);
    end
    run_seg("d6_stable", 1'b1, 1'b1, 10'h040, 10, 1, 6, 4'd6, 1'b0);

    // Release chatter must not produce a pulse; a later clean press does.
    run_seg("chat0", 1'b1, 1'b1, 10'h000, 1, 0, -1, 4'd6, 1'b0);
    run_seg("chat1", 1'b1, 1'b1, 10'h040, 1, 0, -1, 4'd6, 1'b0);
    run_seg("chat2", 1'b1, 1'b1, 10'h000, 1, 0, -1, 4'd6, 1'b0);
    run_seg("chat3", 1'b1, 1'b1, 10'h040, 1, 0, -1, 4'd6, 1'b0);
    run_seg("chat_release", 1'b1, 1'b1, 10'h000, 8, 0, -1, 4'd6, 1'b0);
    run_seg("d6_again", 1'b1, 1'b1, 10'h040, 10, 1, 6, 4'd6, 1'b0);
    run_seg("d6_release", 1'b1, 1'b1, 10'h000, 8, 0, -1, 4'd6, 1'b0);

    // Reset in the middle of debouncing digit 9, then full re-debounce of the held key.
    run_seg("d9_start", 1'b1, 1'b1, 10'h200, 4, 0, -1, 4'd6, 1'b0);
    run_seg("d9_reset", 1'b0, 1'b1, 10'h200, 1, 0, -1, 4'd0, 1'b0);
    run_seg("d9_after", 1'b1, 1'b1, 10'h200, 10, 1, 6, 4'd9, 1'b0);
    run_seg("d9_release", 1'b1, 1'b1, 10'h000, 8, 0, -1, 4'd9, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
